// File: rtl/mem_arbiter_if.sv
// Refill/writeback bus between the icache, dcache, memory and mem_arbiter.
// master = arbiter view, slave = cache/memory environment view.
interface mem_arbiter_if #(parameter int DATA_W = 128);
   logic              i_ren;
   logic [31:0]       i_raddr;
   logic              i_rrdy;
   logic              i_rvalid;

   logic              d_ren;
   logic [31:0]       d_raddr;
   logic              d_rrdy;
   logic              d_rvalid;

   logic [DATA_W-1:0] rdata;

   logic [3:0]        d_wen;
   logic [31:0]       d_waddr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_wrdy;

   logic              mem_req;
   logic              mem_we;
   logic [31:0]       mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_bvalid;

   modport master (
      input  i_ren, i_raddr, d_ren, d_raddr, d_wen, d_waddr, d_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata, mem_bvalid,
      output i_rrdy, i_rvalid, d_rrdy, d_rvalid, rdata, d_wrdy,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output i_ren, i_raddr, d_ren, d_raddr, d_wen, d_waddr, d_wdata,
      output mem_gnt, mem_rvalid, mem_rdata, mem_bvalid,
      input  i_rrdy, i_rvalid, d_rrdy, d_rvalid, rdata, d_wrdy,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter for icache/dcache refills and dcache writebacks.
// Define MEM_ARB_RR_EN for round-robin read arbitration; default is dcache-over-icache priority.
//
// state    | meaning
// IDLE     | no transaction; pick pending write, else a pending read
// RD_ISSUE | read request presented, waiting for mem_gnt
// RD_WAIT  | read accepted, waiting for mem_rvalid
// WR_ISSUE | write request presented, waiting for mem_gnt
// WR_WAIT  | write accepted, waiting for mem_bvalid
module mem_arbiter #(
   parameter int DATA_W = 128
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      WR_ISSUE,
      WR_WAIT
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic              i_pend;
   logic              d_pend;
   logic              w_pend;
   logic [31:0]       i_line;
   logic [31:0]       d_line;
   logic [31:0]       w_line;
   logic [DATA_W-1:0] w_data;

   logic              gnt_d;
   logic              i_rvalid_q;
   logic              d_rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic              mem_we_q;
   logic [31:0]       mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic              mem_req;
   logic              pick_w;
   logic              pick_i;
   logic              pick_d;
   logic              read_sel_d;
   logic              rd_done;
   logic              wr_done;

`ifdef MEM_ARB_RR_EN
   logic              rr_prefer_d;

   assign read_sel_d = d_pend && (!i_pend || rr_prefer_d);

   // Pointer points at the port not granted most recently.
   always_ff @(posedge clk) begin
      if (rst)
         rr_prefer_d <= 1'b1;
      else if (pick_i || pick_d)
         rr_prefer_d <= pick_i;
   end
`else
   assign read_sel_d = d_pend;
`endif

   assign rd_done = (state == RD_WAIT) && bus.mem_rvalid;
   assign wr_done = (state == WR_WAIT) && bus.mem_bvalid;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      pick_w    = 1'b0;
      pick_i    = 1'b0;
      pick_d    = 1'b0;
      case (state)
         IDLE: begin
            if (w_pend) begin
               pick_w    = 1'b1;
               state_nxt = WR_ISSUE;
            end else if (i_pend || d_pend) begin
               pick_d    = read_sel_d;
               pick_i    = !read_sel_d;
               state_nxt = RD_ISSUE;
            end
         end
         RD_ISSUE: begin
            mem_req = 1'b1;
            if (bus.mem_gnt)
               state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            if (bus.mem_rvalid)
               state_nxt = IDLE;
         end
         WR_ISSUE: begin
            mem_req = 1'b1;
            if (bus.mem_gnt)
               state_nxt = WR_WAIT;
         end
         WR_WAIT: begin
            if (bus.mem_bvalid)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_pend      <= 1'b0;
         d_pend      <= 1'b0;
         w_pend      <= 1'b0;
         i_line      <= '0;
         d_line      <= '0;
         w_line      <= '0;
         w_data      <= '0;
         gnt_d       <= 1'b0;
         i_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         rdata_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         i_rvalid_q <= rd_done && !gnt_d;
         d_rvalid_q <= rd_done && gnt_d;
         if (rd_done)
            rdata_q <= bus.mem_rdata;

         // A full slot only clears on completion, so requests seen while full are dropped.
         if (i_pend) begin
            if (rd_done && !gnt_d)
               i_pend <= 1'b0;
         end else if (bus.i_ren) begin
            i_pend <= 1'b1;
            i_line <= {bus.i_raddr[31:4], 4'h0};
         end

         if (d_pend) begin
            if (rd_done && gnt_d)
               d_pend <= 1'b0;
         end else if (bus.d_ren) begin
            d_pend <= 1'b1;
            d_line <= {bus.d_raddr[31:4], 4'h0};
         end

         if (w_pend) begin
            if (wr_done)
               w_pend <= 1'b0;
         end else if (|bus.d_wen) begin
            w_pend <= 1'b1;
            w_line <= {bus.d_waddr[31:4], 4'h0};
            w_data <= bus.d_wdata;
         end

         if (pick_w) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= w_line;
            mem_wdata_q <= w_data;
         end else if (pick_i || pick_d) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= pick_d ? d_line : i_line;
            gnt_d      <= pick_d;
         end
      end
   end

   assign bus.i_rrdy    = !i_pend;
   assign bus.d_rrdy    = !d_pend;
   assign bus.d_wrdy    = !w_pend;
   assign bus.i_rvalid  = i_rvalid_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_req   = mem_req;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule
